// File: rtl/hub_pkg.sv
// ============================================================================
// Module   : hub_pkg
// Purpose  : Shared definitions for the hub slot arbiter: access-size
//            encodings, the fixed request-to-acknowledge latency, and the
//            write-lane mask / write-data replication helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hub_pkg;

    // Access size encodings on req_s. Bit 1 set means long, whatever bit 0 is.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    // Clocks from the grant edge until the acknowledge is visible.
    localparam int HUB_ACK_LAT = 3;

    // Byte write enables for one access. Word accesses ignore a[0];
    // long accesses ignore both low address bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] a_lo);
        logic [3:0] m;
        m = 4'b1111;
        if (size == SZ_BYTE) begin
            m = 4'b0001 << a_lo;
        end else if (size == SZ_WORD) begin
            m = a_lo[1] ? 4'b1100 : 4'b0011;
        end
        return m;
    endfunction

    // Right-justified write data copied into every lane it might land in.
    function automatic logic [31:0] replicate(input logic [1:0]  size,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (size == SZ_BYTE) begin
            r = {4{d[7:0]}};
        end else if (size == SZ_WORD) begin
            r = {2{d[15:0]}};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hub_lane_fmt.sv
// ============================================================================
// Module   : hub_lane_fmt
// Purpose  : Combinational data formatting for the hub path. Builds the RAM
//            byte enables and replicated write data for stage M, and aligns
//            and zero-extends RAM read data for stage Q.
// Ports    : wr_size/wr_alo/wr_data -> wr_mask/wr_rep   (write side)
//            rd_size/rd_alo/rd_q    -> rd_data          (read side)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub_lane_fmt
    import hub_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_alo,
    input  logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_rep,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_alo,
    input  logic [31:0] rd_q,
    output logic [31:0] rd_data
);

    assign wr_mask = lane_mask(wr_size, wr_alo);
    assign wr_rep  = replicate(wr_size, wr_data);

    always_comb begin
        rd_data = rd_q;
        if (rd_size == SZ_BYTE) begin
            case (rd_alo)
                2'd0:    rd_data = {24'd0, rd_q[7:0]};
                2'd1:    rd_data = {24'd0, rd_q[15:8]};
                2'd2:    rd_data = {24'd0, rd_q[23:16]};
                default: rd_data = {24'd0, rd_q[31:24]};
            endcase
        end else if (rd_size == SZ_WORD) begin
            rd_data = rd_alo[1] ? {16'd0, rd_q[31:16]} : {16'd0, rd_q[15:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/hub_slot_arb.sv
// ============================================================================
// Module   : hub_slot_arb
// Purpose  : Round-robin time-slot arbiter giving NCOG cogs access to one
//            shared 32-bit synchronous hub RAM. Three-stage pipeline:
//            C (capture at grant edge), M (drive RAM), Q (align + ack).
// Ports    : clk_cog, nres (sync, active-low)
//            cog_run/req/req_w/req_s/req_a/req_d : per-cog request buses
//            ack/rdata                           : one-hot completion + data
//            slot                                : current slot owner
//            mem_en/mem_we/mem_a/mem_d/mem_q     : RAM macro interface
// Config   : HUB_SLOT_SKIP_EN - when defined, slot changes skip cogs whose
//            cog_run bit is clear; otherwise every slot is visited.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub_slot_arb
    import hub_pkg::*;
#(
    parameter int NCOG     = 8,
    parameter int AW       = 16,
    parameter int SLOT_CYC = 2
) (
    input  logic                    clk_cog,
    input  logic                    nres,
    input  logic [NCOG-1:0]         cog_run,
    input  logic [NCOG-1:0]         req,
    input  logic [NCOG-1:0]         req_w,
    input  logic [2*NCOG-1:0]       req_s,
    input  logic [AW*NCOG-1:0]      req_a,
    input  logic [32*NCOG-1:0]      req_d,
    output logic [NCOG-1:0]         ack,
    output logic [31:0]             rdata,
    output logic [$clog2(NCOG)-1:0] slot,
    output logic                    mem_en,
    output logic [3:0]              mem_we,
    output logic [AW-3:0]           mem_a,
    output logic [31:0]             mem_d,
    input  logic [31:0]             mem_q
);

    localparam int             SW      = $clog2(NCOG);
    localparam int             PW      = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [PW-1:0]  PH_LAST = PW'(SLOT_CYC - 1);
    localparam logic [NCOG-1:0] ACK_ONE = {{(NCOG-1){1'b0}}, 1'b1};

    // Per-cog views of the packed request buses.
    logic [AW-1:0] w_a_arr [NCOG];
    logic [31:0]   w_d_arr [NCOG];
    logic [1:0]    w_s_arr [NCOG];

    for (genvar k = 0; k < NCOG; k++) begin : g_unpack
        assign w_a_arr[k] = req_a[k*AW +: AW];
        assign w_d_arr[k] = req_d[k*32 +: 32];
        assign w_s_arr[k] = req_s[k*2 +: 2];
    end

    // ------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------
    logic [PW-1:0] r_phase;
    logic          w_last;
    logic [SW-1:0] w_slot_nxt;
    logic          w_grant;

    assign w_last = (r_phase == PH_LAST);

`ifdef HUB_SLOT_SKIP_EN
    // Nearest running cog after the current one, searching cyclically.
    // The final iteration lands back on the current slot, so a lone
    // running cog keeps its slot; with nobody running the slot holds.
    always_comb begin : p_skip
        logic [SW-1:0] v_idx;
        logic          v_found;
        w_slot_nxt = slot;
        v_found    = 1'b0;
        v_idx      = '0;
        for (int i = 1; i <= NCOG; i++) begin
            v_idx = slot + SW'(i);
            if (!v_found && cog_run[v_idx]) begin
                w_slot_nxt = v_idx;
                v_found    = 1'b1;
            end
        end
    end
`else
    assign w_slot_nxt = slot + SW'(1);
`endif

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            r_phase <= '0;
            slot    <= '0;
        end else if (w_last) begin
            r_phase <= '0;
            slot    <= w_slot_nxt;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

    assign w_grant = w_last && req[slot] && cog_run[slot];

    // ------------------------------------------------------------------
    // Stage C: capture the slot owner's request at its grant edge
    // ------------------------------------------------------------------
    logic          r_c_v;
    logic          r_c_w;
    logic [1:0]    r_c_s;
    logic [AW-1:0] r_c_a;
    logic [31:0]   r_c_d;
    logic [SW-1:0] r_c_own;

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            r_c_v   <= 1'b0;
            r_c_w   <= 1'b0;
            r_c_s   <= '0;
            r_c_a   <= '0;
            r_c_d   <= '0;
            r_c_own <= '0;
        end else begin
            r_c_v <= w_grant;
            if (w_grant) begin
                r_c_w   <= req_w[slot];
                r_c_s   <= w_s_arr[slot];
                r_c_a   <= w_a_arr[slot];
                r_c_d   <= w_d_arr[slot];
                r_c_own <= slot;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane formatting (shared by stages M and Q)
    // ------------------------------------------------------------------
    logic [3:0]  w_mask;
    logic [31:0] w_rep;
    logic [31:0] w_rd_data;
    logic [1:0]  r_q_s;
    logic [1:0]  r_q_alo;

    hub_lane_fmt u_lane_fmt (
        .wr_size (r_c_s),
        .wr_alo  (r_c_a[1:0]),
        .wr_data (r_c_d),
        .wr_mask (w_mask),
        .wr_rep  (w_rep),
        .rd_size (r_q_s),
        .rd_alo  (r_q_alo),
        .rd_q    (mem_q),
        .rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Stage M: drive the RAM. Address/data/enables hold between accesses.
    // ------------------------------------------------------------------
    logic          r_m_v;
    logic          r_m_w;
    logic [1:0]    r_m_s;
    logic [1:0]    r_m_alo;
    logic [SW-1:0] r_m_own;

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            mem_en  <= 1'b0;
            mem_we  <= '0;
            mem_a   <= '0;
            mem_d   <= '0;
            r_m_v   <= 1'b0;
            r_m_w   <= 1'b0;
            r_m_s   <= '0;
            r_m_alo <= '0;
            r_m_own <= '0;
        end else begin
            mem_en <= r_c_v;
            r_m_v  <= r_c_v;
            if (r_c_v) begin
                mem_a   <= r_c_a[AW-1:2];
                mem_we  <= r_c_w ? w_mask : 4'b0000;
                mem_d   <= w_rep;
                r_m_w   <= r_c_w;
                r_m_s   <= r_c_s;
                r_m_alo <= r_c_a[1:0];
                r_m_own <= r_c_own;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage Q: RAM output is valid this cycle; align it and acknowledge.
    // ------------------------------------------------------------------
    logic          r_q_v;
    logic          r_q_w;
    logic [SW-1:0] r_q_own;

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            r_q_v   <= 1'b0;
            r_q_w   <= 1'b0;
            r_q_s   <= '0;
            r_q_alo <= '0;
            r_q_own <= '0;
        end else begin
            r_q_v <= r_m_v;
            if (r_m_v) begin
                r_q_w   <= r_m_w;
                r_q_s   <= r_m_s;
                r_q_alo <= r_m_alo;
                r_q_own <= r_m_own;
            end
        end
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            ack   <= '0;
            rdata <= '0;
        end else begin
            ack <= r_q_v ? (ACK_ONE << r_q_own) : '0;
            if (r_q_v) begin
                rdata <= r_q_w ? 32'd0 : w_rd_data;
            end
        end
    end

endmodule

`default_nettype wire
